timer_countdown: RTL and testbench

TIMER_COUNTDOWN -- requirements
Module: timer_countdown

---
 rtl/timer_countdown.sv | 168 ++++++++++++++++
 tb/tb_timer_countdown.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown.sv
// MM:SS countdown timer with load/start/pause/clear strobes, one-second prescaler and alarm.
// Optional feature: define TIMER_ALARM_BLINK_EN to make o_alarm blink at half-second rate in ALARM.
module timer_countdown #(
  parameter int TICKS_PER_SEC = 25000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_min,
  input  logic [5:0] i_seg,
  input  logic       i_load,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_clear,
  output logic [5:0] o_min,
  output logic [5:0] o_seg,
  output logic       o_running,
  output logic       o_done,
  output logic       o_alarm
);

  localparam int            PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [5:0]    r_min;
  logic [5:0]    r_seg;
  logic [5:0]    w_min_next;
  logic [5:0]    w_seg_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_done;
  logic          w_done_next;

  // Preset fields clamped to 59; index 0 is seconds, 1 is minutes.
  logic [5:0] w_preset  [2];
  logic [5:0] w_clamped [2];

  assign w_preset[0] = i_seg;
  assign w_preset[1] = i_min;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
      assign w_clamped[gi] = (w_preset[gi] > 6'd59) ? 6'd59 : w_preset[gi];
    end
  endgenerate

  // Only the highest-priority asserted strobe is considered each cycle.
  logic w_sel_clear;
  logic w_sel_load;
  logic w_sel_start;
  logic w_sel_pause;
  logic w_can_set;
  logic w_count_zero;
  logic w_last_second;

  assign w_sel_clear   = i_clear;
  assign w_sel_load    = !i_clear && i_load;
  assign w_sel_start   = !i_clear && !i_load && i_start;
  assign w_sel_pause   = !i_clear && !i_load && !i_start && i_pause;
  assign w_can_set     = (r_state == S_IDLE) || (r_state == S_PAUSE);
  assign w_count_zero  = (r_min == 6'd0) && (r_seg == 6'd0);
  assign w_last_second = (r_min == 6'd0) && (r_seg == 6'd1);

  always_comb begin
    w_state_next = r_state;
    w_min_next   = r_min;
    w_seg_next   = r_seg;
    w_presc_next = r_presc;
    w_done_next  = 1'b0;

    if (w_sel_clear) begin
      w_state_next = S_IDLE;
      w_min_next   = 6'd0;
      w_seg_next   = 6'd0;
      w_presc_next = '0;
    end else if (w_sel_load && w_can_set) begin
      w_state_next = S_IDLE;
      w_min_next   = w_clamped[1];
      w_seg_next   = w_clamped[0];
      w_presc_next = '0;
    end else if (w_sel_start && w_can_set && !w_count_zero) begin
      // Prescaler is kept so a resume continues the interrupted second.
      w_state_next = S_RUN;
    end else if (w_sel_pause && (r_state == S_RUN)) begin
      w_state_next = S_PAUSE;
    end else if (r_state == S_RUN) begin
      if (r_presc == PRESC_LAST) begin
        w_presc_next = '0;
        if (r_seg != 6'd0) begin
          w_seg_next = r_seg - 6'd1;
        end else if (r_min != 6'd0) begin
          w_seg_next = 6'd59;
          w_min_next = r_min - 6'd1;
        end
        if (w_last_second) begin
          w_done_next  = 1'b1;
          w_state_next = S_ALARM;
        end
      end else begin
        w_presc_next = r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_min   <= 6'd0;
      r_seg   <= 6'd0;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_min   <= w_min_next;
      r_seg   <= w_seg_next;
      r_presc <= w_presc_next;
      r_done  <= w_done_next;
    end
  end

`ifdef TIMER_ALARM_BLINK_EN
  localparam int            HALF       = TICKS_PER_SEC / 2;
  localparam int            BW         = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_alarm;

  // Blink phase restarts high on every ALARM entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blink_cnt <= '0;
      r_alarm     <= 1'b0;
    end else if ((w_state_next == S_ALARM) && (r_state != S_ALARM)) begin
      r_blink_cnt <= '0;
      r_alarm     <= 1'b1;
    end else if ((w_state_next == S_ALARM) && (r_state == S_ALARM)) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_alarm     <= ~r_alarm;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end else begin
      r_blink_cnt <= '0;
      r_alarm     <= 1'b0;
    end
  end

  assign o_alarm = r_alarm;
`else
  assign o_alarm = (r_state == S_ALARM);
`endif

  assign o_min     = r_min;
  assign o_seg     = r_seg;
  assign o_running = (r_state == S_RUN);
  assign o_done    = r_done;

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: directed scenarios plus randomized strobes against a seconds-level model.
module tb_timer_countdown;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_load = 1'b0;
  logic       i_start = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_clear = 1'b0;
  logic [5:0] i_min = 6'd0;
  logic [5:0] i_seg = 6'd0;
  logic [5:0] o_min;
  logic [5:0] o_seg;
  logic       o_running;
  logic       o_done;
  logic       o_alarm;

  int n_cmp = 0;
  int n_err = 0;

  timer_countdown #(.TICKS_PER_SEC(T)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_min    (i_min),
    .i_seg    (i_seg),
    .i_load   (i_load),
    .i_start  (i_start),
    .i_pause  (i_pause),
    .i_clear  (i_clear),
    .o_min    (o_min),
    .o_seg    (o_seg),
    .o_running(o_running),
    .o_done   (o_done),
    .o_alarm  (o_alarm)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as total seconds, plus cycles elapsed in the current second.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_phase = 0;
  int m_alarm_age = 0;
  bit m_done = 1'b0;

  function automatic bit m_alarm_exp();
`ifdef TIMER_ALARM_BLINK_EN
    return (m_mode == M_ALARM) && (((m_alarm_age / (T / 2)) % 2) == 0);
`else
    return (m_mode == M_ALARM);
`endif
  endfunction

  function automatic bit blink_exp(input int age);
`ifdef TIMER_ALARM_BLINK_EN
    return ((age / (T / 2)) % 2) == 0;
`else
    return (age >= 0);
`endif
  endfunction

  task automatic model_edge(input bit rst, clr, ld, st, pa, input int mn, sc);
    int prev;
    bit adv;
    prev   = m_mode;
    adv    = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0;
    end else if (clr) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0;
    end else if (ld) begin
      if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
        m_secs  = ((mn > 59) ? 59 : mn) * 60 + ((sc > 59) ? 59 : sc);
        m_phase = 0;
        m_mode  = M_IDLE;
      end else adv = 1'b1;
    end else if (st) begin
      if ((m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs > 0) m_mode = M_RUN;
      else adv = 1'b1;
    end else if (pa) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else adv = 1'b1;
    if (adv && prev == M_RUN) begin
      m_phase++;
      if (m_phase == T) begin
        m_phase = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_done = 1'b1;
          m_mode = M_ALARM;
        end
      end
    end
    m_alarm_age = (prev == M_ALARM && m_mode == M_ALARM) ? m_alarm_age + 1 : 0;
  endtask

  task automatic step(input bit rst, clr, ld, st, pa, input int mn, sc);
    i_reset = rst; i_clear = clr; i_load = ld; i_start = st; i_pause = pa;
    i_min = 6'(mn); i_seg = 6'(sc);
    @(posedge clk);
    model_edge(rst, clr, ld, st, pa, mn, sc);
    #1;
    i_reset = 1'b0; i_clear = 1'b0; i_load = 1'b0; i_start = 1'b0; i_pause = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({o_min, o_seg, o_running, o_done, o_alarm} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {o_min, o_seg, o_running, o_done, o_alarm});
    end
    idle(1);
    $display("reset: outputs %h after release", {o_min, o_seg, o_running, o_done, o_alarm});
  endtask

  task automatic test_load_run();
    step(0, 0, 1, 0, 0, 0, 3);
    n_cmp++;
    if (o_min !== 6'd0 || o_seg !== 6'd3) begin
      n_err++; $display("FAIL load_run_load: got %0d:%0d required 0:3", o_min, o_seg);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (o_running !== 1'b1) begin
      n_err++; $display("FAIL load_run_running: got %b required 1", o_running);
    end
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      if (k % 4 == 0) begin
        n_cmp++;
        if (o_seg !== 6'(3 - k / 4)) begin
          n_err++; $display("FAIL load_run_seg k=%0d: got %0d required %0d", k, o_seg, 3 - k / 4);
        end
      end
      n_cmp++;
      if (o_done !== (k == 12)) begin
        n_err++; $display("FAIL load_run_done k=%0d: got %b required %b", k, o_done, (k == 12));
      end
    end
    for (int j = 0; j < 8; j++) begin
      if (j > 0) idle(1);
      n_cmp++;
      if (o_alarm !== blink_exp(j) || o_running !== 1'b0 || (j > 0 && o_done !== 1'b0)) begin
        n_err++;
        $display("FAIL load_run_alarm j=%0d: got alarm=%b run=%b done=%b required alarm=%b run=0", j, o_alarm, o_running, o_done, blink_exp(j));
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (o_alarm !== 1'b0 || o_running !== 1'b0 || o_min !== 6'd0 || o_seg !== 6'd0) begin
      n_err++; $display("FAIL alarm_clear: got alarm=%b run=%b %0d:%0d required 0 0 0:0", o_alarm, o_running, o_min, o_seg);
    end
    $display("load_run: countdown 00:03 finished and alarm cleared");
  endtask

  task automatic test_minute_borrow();
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(4);
    n_cmp++;
    if (o_min !== 6'd0 || o_seg !== 6'd59) begin
      n_err++; $display("FAIL borrow_first: got %0d:%0d required 0:59", o_min, o_seg);
    end
    idle(235);
    n_cmp++;
    if (o_min !== 6'd0 || o_seg !== 6'd1 || o_done !== 1'b0) begin
      n_err++; $display("FAIL borrow_239: got %0d:%0d done=%b required 0:1 done=0", o_min, o_seg, o_done);
    end
    idle(1);
    n_cmp++;
    if (o_min !== 6'd0 || o_seg !== 6'd0 || o_done !== 1'b1) begin
      n_err++; $display("FAIL borrow_240: got %0d:%0d done=%b required 0:0 done=1", o_min, o_seg, o_done);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    $display("borrow: 01:00 counted down to 00:00");
  endtask

  task automatic test_clamp_ignore();
    step(0, 0, 1, 0, 0, 63, 60);
    n_cmp++;
    if (o_min !== 6'd59 || o_seg !== 6'd59) begin
      n_err++; $display("FAIL clamp: got %0d:%0d required 59:59", o_min, o_seg);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (o_running !== 1'b0 || o_done !== 1'b0 || o_min !== 6'd0 || o_seg !== 6'd0) begin
        n_err++; $display("FAIL zero_start k=%0d: got run=%b done=%b %0d:%0d required 0 0 0:0", k, o_running, o_done, o_min, o_seg);
      end
      idle(1);
    end
    $display("clamp_ignore: 63:60 clamped, start at 00:00 ignored");
  endtask

  task automatic test_pause_resume();
    step(0, 0, 1, 0, 0, 0, 5);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      idle(1);
      n_cmp++;
      if (o_seg !== 6'd5 || o_min !== 6'd0 || o_running !== 1'b0) begin
        n_err++; $display("FAIL pause_hold k=%0d: got %0d:%0d run=%b required 0:5 run=0", k, o_min, o_seg, o_running);
      end
    end
    step(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    n_cmp++;
    if (o_seg !== 6'd5) begin
      n_err++; $display("FAIL resume_plus1: got %0d required 5", o_seg);
    end
    idle(1);
    n_cmp++;
    if (o_seg !== 6'd4 || o_running !== 1'b1) begin
      n_err++; $display("FAIL resume_plus2: got %0d run=%b required 4 run=1", o_seg, o_running);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    $display("pause_resume: partial second preserved across pause");
  endtask

  task automatic test_simul_strobes();
    step(0, 0, 1, 0, 0, 0, 10);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 1, 0, 0);
    n_cmp++;
    if (o_running !== 1'b0 || o_min !== 6'd0 || o_seg !== 6'd0) begin
      n_err++; $display("FAIL clear_pause: got run=%b %0d:%0d required 0 0:0", o_running, o_min, o_seg);
    end
    step(0, 0, 1, 1, 0, 0, 7);
    idle(2);
    n_cmp++;
    if (o_running !== 1'b0 || o_seg !== 6'd7) begin
      n_err++; $display("FAIL load_start: got run=%b seg=%0d required 0 7", o_running, o_seg);
    end
    step(0, 1, 1, 1, 0, 5, 5);
    n_cmp++;
    if (o_running !== 1'b0 || o_min !== 6'd0 || o_seg !== 6'd0) begin
      n_err++; $display("FAIL clear_load_start: got run=%b %0d:%0d required 0 0:0", o_running, o_min, o_seg);
    end
    $display("simul_strobes: clear > load > start priority observed");
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 0, 0, 0, 2);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(6);
    step(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({o_min, o_seg, o_running, o_done, o_alarm} !== 15'd0) begin
      n_err++; $display("FAIL reset_mid: got %h required 0", {o_min, o_seg, o_running, o_done, o_alarm});
    end
    for (int k = 0; k < 6; k++) begin
      idle(1);
      n_cmp++;
      if (o_done !== 1'b0 || o_running !== 1'b0 || o_seg !== 6'd0) begin
        n_err++; $display("FAIL reset_mid_after k=%0d: got done=%b run=%b seg=%0d required 0 0 0", k, o_done, o_running, o_seg);
      end
    end
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(4);
    n_cmp++;
    if (o_alarm !== 1'b1 || o_done !== 1'b1) begin
      n_err++; $display("FAIL alarm_entry: got alarm=%b done=%b required 1 1", o_alarm, o_done);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({o_min, o_seg, o_running, o_done, o_alarm} !== 15'd0) begin
      n_err++; $display("FAIL reset_alarm: got %h required 0", {o_min, o_seg, o_running, o_done, o_alarm});
    end
    $display("reset_mid: countdown cancelled without done pulse");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_err;
    for (int c = 0; c < 4000; c++) begin
      bit rst, clr, ld, st, pa;
      int mn, sc;
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 5) == 0);
      pa  = ($urandom_range(0, 29) == 0);
      mn  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : 0;
      sc  = int'($urandom_range(0, 63));
      step(rst, clr, ld, st, pa, mn, sc);
      n_cmp++;
      if (o_min !== 6'(m_secs / 60) || o_seg !== 6'(m_secs % 60)) begin
        n_err++; $display("FAIL rand_count cycle %0d: got %0d:%0d required %0d:%0d", c, o_min, o_seg, m_secs / 60, m_secs % 60);
      end
      n_cmp++;
      if (o_running !== (m_mode == M_RUN) || o_done !== m_done || o_alarm !== m_alarm_exp()) begin
        n_err++;
        $display("FAIL rand_flags cycle %0d: got run=%b done=%b alarm=%b required run=%b done=%b alarm=%b",
                 c, o_running, o_done, o_alarm, (m_mode == M_RUN), m_done, m_alarm_exp());
      end
    end
    $display("random: 4000 cycles, %0d new mismatches", n_err - errs_before);
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_minute_borrow();
    test_clamp_ignore();
    test_pause_resume();
    test_simul_strobes();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
